// File: rtl/saph_plr_hs.sv
`default_nettype none
// ============================================================================
// Module      : saph_plr_hs
// Description : Elastic valid/ready pipeline register chain with bubble
//               collapse and flush. Optional output skid register enabled
//               by defining SAPH_PLR_SKID_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module saph_plr_hs #(
    parameter  int WIDTH   = 1,
    parameter  int LATENCY = 1,
    localparam int OCC_W   = $clog2(LATENCY + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic             d_ready,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic [OCC_W-1:0] occupancy
);

    generate
        if (LATENCY == 0) begin : g_pass
            logic w_unused;
            assign w_unused  = ^{clk, rst, flush};
            assign q         = d;
            assign q_valid   = d_valid;
            assign d_ready   = q_ready;
            assign occupancy = '0;
        end else begin : g_pipe
            logic [LATENCY-1:0] r_valid;
            logic [LATENCY-1:0] w_in_valid;
            logic [LATENCY-1:0] w_valid_nxt;
            logic [LATENCY:0]   w_rdy;
            logic [WIDTH-1:0]   r_data [LATENCY];
            logic [WIDTH-1:0]   w_din  [LATENCY];
            logic [OCC_W-1:0]   r_occ;
            logic [OCC_W-1:0]   w_occ_nxt;
            logic               w_rdy_end;
            logic               w_skid_cnt;

`ifdef SAPH_PLR_SKID_EN
            logic             r_skid_valid;
            logic [WIDTH-1:0] r_skid_data;
            logic             w_skid_valid_nxt;

            // Skid empty: last stage always leaves, either downstream or into the skid.
            assign w_rdy_end        = !r_skid_valid;
            assign w_skid_valid_nxt = r_skid_valid ? !q_ready
                                                   : (r_valid[LATENCY-1] && !q_ready);
            assign w_skid_cnt       = w_skid_valid_nxt;
            assign q       = r_skid_valid ? r_skid_data : r_data[LATENCY-1];
            assign q_valid = r_skid_valid || r_valid[LATENCY-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_skid_valid <= 1'b0;
                    r_skid_data  <= '0;
                end else if (flush) begin
                    r_skid_valid <= 1'b0;
                end else begin
                    r_skid_valid <= w_skid_valid_nxt;
                    if (!r_skid_valid && r_valid[LATENCY-1] && !q_ready) begin
                        r_skid_data <= r_data[LATENCY-1];
                    end
                end
            end
`else
            assign w_rdy_end  = q_ready;
            assign w_skid_cnt = 1'b0;
            assign q          = r_data[LATENCY-1];
            assign q_valid    = r_valid[LATENCY-1];
`endif

            always_comb begin
                w_rdy          = '0;
                w_rdy[LATENCY] = w_rdy_end;
                for (int k = LATENCY - 1; k >= 0; k--) begin
                    w_rdy[k] = !r_valid[k] || w_rdy[k+1];
                end
                w_in_valid    = '0;
                w_in_valid[0] = d_valid;
                w_din[0]      = d;
                for (int k = 1; k < LATENCY; k++) begin
                    w_in_valid[k] = r_valid[k-1];
                    w_din[k]      = r_data[k-1];
                end
                w_valid_nxt = '0;
                w_occ_nxt   = OCC_W'(w_skid_cnt);
                for (int k = 0; k < LATENCY; k++) begin
                    w_valid_nxt[k] = w_rdy[k] ? w_in_valid[k] : r_valid[k];
                    w_occ_nxt      = w_occ_nxt + OCC_W'(w_valid_nxt[k]);
                end
            end

            assign d_ready   = w_rdy[0] && !flush;
            assign occupancy = r_occ;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= '0;
                    r_occ   <= '0;
                    for (int k = 0; k < LATENCY; k++) begin
                        r_data[k] <= '0;
                    end
                end else if (flush) begin
                    r_valid <= '0;
                    r_occ   <= '0;
                end else begin
                    r_valid <= w_valid_nxt;
                    r_occ   <= w_occ_nxt;
                    for (int k = 0; k < LATENCY; k++) begin
                        if (w_rdy[k] && w_in_valid[k]) begin
                            r_data[k] <= w_din[k];
                        end
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_saph_plr_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_saph_plr_hs
// Description : Scoreboard bench for saph_plr_hs (latency 3, 2 and 0 builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_saph_plr_hs;

`ifdef SAPH_PLR_SKID_EN
    localparam int CAP3 = 4;
    localparam int CAP2 = 3;
`else
    localparam int CAP3 = 3;
    localparam int CAP2 = 2;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // latency 3 instance
    logic       rst, flush, d_valid, d_ready, q_valid, q_ready;
    logic [7:0] d, q;
    logic [2:0] occ;
    // latency 2 instance
    logic       rst2, flush2, d_valid2, d_ready2, q_valid2, q_ready2;
    logic [7:0] d2, q2;
    logic [1:0] occ2;
    // latency 0 instance
    logic       fl0, dv0, dr0, qv0, qr0;
    logic [7:0] d0, q0;
    logic [0:0] occ0;

    saph_plr_hs #(.WIDTH(8), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .flush(flush), .d(d), .d_valid(d_valid), .d_ready(d_ready),
        .q(q), .q_valid(q_valid), .q_ready(q_ready), .occupancy(occ));

    saph_plr_hs #(.WIDTH(8), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst2), .flush(flush2), .d(d2), .d_valid(d_valid2), .d_ready(d_ready2),
        .q(q2), .q_valid(q_valid2), .q_ready(q_ready2), .occupancy(occ2));

    saph_plr_hs #(.WIDTH(8), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(fl0), .d(d0), .d_valid(dv0), .d_ready(dr0),
        .q(q0), .q_valid(qv0), .q_ready(qr0), .occupancy(occ0));

    int checks   = 0;
    int failures = 0;
    int max_occ2 = 0;
    logic [7:0] exp3 [$];
    logic [7:0] exp2 [$];
    logic [7:0] e3, e2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: a beat leaves whenever q_valid && q_ready at the next edge.
    always @(negedge clk) begin
        if (q_valid && q_ready) begin
            checks++;
            if (exp3.size() == 0) begin
                failures++;
                $display("FAIL mon3_extra actual=0x%0h required=none", q);
            end else begin
                e3 = exp3.pop_front();
                if (q !== e3) begin
                    failures++;
                    $display("FAIL mon3_data actual=0x%0h required=0x%0h", q, e3);
                end
            end
        end
        if (q_valid2 && q_ready2) begin
            checks++;
            if (exp2.size() == 0) begin
                failures++;
                $display("FAIL mon2_extra actual=0x%0h required=none", q2);
            end else begin
                e2 = exp2.pop_front();
                if (q2 !== e2) begin
                    failures++;
                    $display("FAIL mon2_data actual=0x%0h required=0x%0h", q2, e2);
                end
            end
        end
        if (int'(occ2) > max_occ2) max_occ2 = int'(occ2);
    end

    task automatic drain3();
        q_ready = 1'b1;
        for (int n = 0; n < 30 && exp3.size() != 0; n++) step();
        repeat (6) step();
        chk("drain3_empty", exp3.size(), 0);
    endtask

    task automatic send3(input logic [7:0] v);
        int n;
        n       = 0;
        d       = v;
        d_valid = 1'b1;
        #1;
        while (!d_ready && n < 30) begin
            step();
            n++;
        end
        chk("send3_accept", d_ready, 1);
        step();
        d_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; d = '0; d_valid = 1'b0; q_ready = 1'b0;
        rst2 = 1'b1; flush2 = 1'b0; d2 = '0; d_valid2 = 1'b0; q_ready2 = 1'b0;
        fl0 = 1'b0; dv0 = 1'b0; qr0 = 1'b0; d0 = '0;
        step();
        step();
        chk("rst_q_valid", q_valid, 0);
        chk("rst_q", q, 0);
        chk("rst_occ", occ, 0);
        chk("rst_d_ready", d_ready, 1);
        rst = 1'b0; rst2 = 1'b0;

        // latency 0: pure pass-through, flush ignored
        d0 = 8'h5A; dv0 = 1'b1; qr0 = 1'b0; fl0 = 1'b1;
        #1;
        chk("l0_q", q0, 8'h5A);
        chk("l0_q_valid", qv0, 1);
        chk("l0_d_ready_lo", dr0, 0);
        chk("l0_occ", occ0, 0);
        qr0 = 1'b1;
        #1;
        chk("l0_d_ready_hi", dr0, 1);

        // straight-through stream, fixed latency 3
        step();
        q_ready = 1'b1;
        exp3.push_back(8'h11); exp3.push_back(8'h22); exp3.push_back(8'h33);
        d = 8'h11; d_valid = 1'b1; #1; chk("t1_rdy0", d_ready, 1); step();
        d = 8'h22;                 #1; chk("t1_rdy1", d_ready, 1); step();
        d = 8'h33;                 #1; chk("t1_rdy2", d_ready, 1);
        chk("t1_not_yet", q_valid, 0);
        step();
        d_valid = 1'b0;
        #1;
        chk("t1_lat", q_valid, 1);
        drain3();

        // stall until full, then release
        q_ready = 1'b0;
        for (int i = 0; i < 5; i++) exp3.push_back(8'hA0 + 8'(i));
        for (int i = 0; i < CAP3; i++) begin
            d = 8'hA0 + 8'(i); d_valid = 1'b1;
            #1;
            chk("t2_accept", d_ready, 1);
            step();
        end
        d = 8'hA0 + 8'(CAP3);
        #1;
        chk("t2_full_rdy", d_ready, 0);
        chk("t2_full_occ", occ, CAP3);
        step();
        chk("t2_still_full", d_ready, 0);
        q_ready = 1'b1;
`ifndef SAPH_PLR_SKID_EN
        #1;
        chk("t2_rdy_chain", d_ready, 1);
`endif
        for (int i = CAP3; i < 5; i++) send3(8'hA0 + 8'(i));
        drain3();

        // bubble collapse under stall
        exp3.push_back(8'h01); exp3.push_back(8'h02);
        d = 8'h01; d_valid = 1'b1; step();
        d_valid = 1'b0;            step();
        d = 8'h02; d_valid = 1'b1; step();
        d_valid = 1'b0; q_ready = 1'b0;
        #1;
        chk("t3_q_valid", q_valid, 1);
        chk("t3_q_c3", q, 8'h01);
        step();
        chk("t3_occ", occ, 2);
        chk("t3_q_c4", q, 8'h01);
        step();
        chk("t3_q_c5", q, 8'h01);
        chk("t3_qv_c5", q_valid, 1);
        drain3();

        // flush discards everything, including the beat offered that cycle
        q_ready = 1'b0;
        for (int i = 0; i < CAP3; i++) begin
            d = 8'hB0 + 8'(i); d_valid = 1'b1;
            step();
        end
        d_valid = 1'b0;
        #1;
        chk("t4_occ_full", occ, CAP3);
        flush = 1'b1; d = 8'h55; d_valid = 1'b1;
        #1;
        chk("t4_flush_rdy", d_ready, 0);
        step();
        flush = 1'b0; d_valid = 1'b0;
        #1;
        chk("t4_q_valid", q_valid, 0);
        chk("t4_occ", occ, 0);
        chk("t4_d_ready", d_ready, 1);
        drain3();

        // latency 2: reset while full, and reset together with flush
        q_ready2 = 1'b0;
        for (int i = 0; i < CAP2; i++) begin
            d2 = 8'hC0 + 8'(i); d_valid2 = 1'b1;
            step();
        end
        d_valid2 = 1'b0;
        #1;
        chk("t5_occ_full", occ2, CAP2);
        chk("t5_rdy_full", d_ready2, 0);
        rst2 = 1'b1; step(); rst2 = 1'b0;
        chk("t5_rst_qv", q_valid2, 0);
        chk("t5_rst_q", q2, 0);
        chk("t5_rst_occ", occ2, 0);
        for (int i = 0; i < CAP2; i++) begin
            d2 = 8'hD0 + 8'(i); d_valid2 = 1'b1;
            step();
        end
        d_valid2 = 1'b0;
        rst2 = 1'b1; flush2 = 1'b1; step(); rst2 = 1'b0; flush2 = 1'b0;
        chk("t5_rf_qv", q_valid2, 0);
        chk("t5_rf_q", q2, 0);
        chk("t5_rf_occ", occ2, 0);

`ifdef SAPH_PLR_SKID_EN
        // skid: toggling q_ready under continuous input
        begin
            int idx;
            logic acc;
            idx = 0;
            max_occ2 = 0;
            for (int i = 0; i < 16; i++) exp2.push_back(8'(i));
            for (int cyc = 0; cyc < 200 && idx < 16; cyc++) begin
                q_ready2 = (cyc % 2) == 1;
                d2 = 8'(idx); d_valid2 = 1'b1;
                #1;
                acc = d_ready2;
                step();
                if (acc) idx++;
            end
            d_valid2 = 1'b0;
            chk("t6_all_sent", idx, 16);
            q_ready2 = 1'b1;
            for (int n = 0; n < 30 && exp2.size() != 0; n++) step();
            repeat (4) step();
            chk("t6_drained", exp2.size(), 0);
            chk("t6_occ_max", max_occ2 <= 3, 1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
